// File: rtl/actuador_maquina_if.sv
// Command/sensor and actuator bundle between the coffee-machine sequencer and
// the actuator controller actuador_maquina.
interface actuador_maquina_if;
    logic [2:0] cmd;
    logic       taza;
    logic       mol_cafe;
    logic       dos_te;
    logic       valv_agua;
    logic       dev_moneda;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd, taza,
        input  mol_cafe, dos_te, valv_agua, dev_moneda, busy, done, err
    );

    modport slave (
        input  cmd, taza,
        output mol_cafe, dos_te, valv_agua, dev_moneda, busy, done, err
    );
endinterface

// File: rtl/actuador_maquina.sv
// Actuator sequencer for grinder, tea doser, hot-water valve and coin return.
// Optional macro ACTUADOR_CUP_SENSE_EN enables cup sensing (refusal and pause).
module actuador_maquina #(
    parameter int unsigned T_MOLER = 8,
    parameter int unsigned T_TE    = 4,
    parameter int unsigned T_AGUA  = 16,
    parameter int unsigned T_DEV   = 4
) (
    input  logic               clk,
    input  logic               rst,
    actuador_maquina_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MOLER    = 3'd1;
    localparam logic [2:0] S_DOSIS    = 3'd2;
    localparam logic [2:0] S_SERVIR   = 3'd3;
    localparam logic [2:0] S_PAUSA    = 3'd4;
    localparam logic [2:0] S_DEVOLVER = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    localparam int unsigned T_MAX_A = (T_MOLER > T_TE)  ? T_MOLER : T_TE;
    localparam int unsigned T_MAX_B = (T_AGUA  > T_DEV) ? T_AGUA  : T_DEV;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CW      = $clog2(T_MAX + 32'd1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] LD_MOLER = CW'(T_MOLER - 32'd1);
    localparam logic [CW-1:0] LD_TE    = CW'(T_TE    - 32'd1);
    localparam logic [CW-1:0] LD_AGUA  = CW'(T_AGUA  - 32'd1);
    localparam logic [CW-1:0] LD_DEV   = CW'(T_DEV   - 32'd1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          err_q, err_d;
    logic          mol_cafe_q, mol_cafe_d;
    logic          dos_te_q, dos_te_d;
    logic          valv_agua_q, valv_agua_d;
    logic          dev_moneda_q, dev_moneda_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cup_ok_s;

`ifdef ACTUADOR_CUP_SENSE_EN
    assign cup_ok_s = bus.taza;
`else
    assign cup_ok_s = 1'b1;
`endif

    // Next-state, counter and armed-flag logic; cnt holds remaining cycles minus one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (bus.cmd == 3'b000) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    if (((bus.cmd == 3'b001) || (bus.cmd == 3'b010)) && !cup_ok_s) begin
                        state_d = S_DEVOLVER;
                        cnt_d   = LD_DEV;
                        err_d   = 1'b1;
                    end else if (bus.cmd == 3'b001) begin
                        state_d = S_MOLER;
                        cnt_d   = LD_MOLER;
                    end else if (bus.cmd == 3'b010) begin
                        state_d = S_DOSIS;
                        cnt_d   = LD_TE;
                    end else begin
                        state_d = S_DEVOLVER;
                        cnt_d   = LD_DEV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MOLER, S_DOSIS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_SERVIR;
                    cnt_d   = LD_AGUA;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SERVIR: begin
                // The cycle in which the cup is seen missing still had the valve open.
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_FIN;
                    armed_d = 1'b0;
                end else if (!cup_ok_s) begin
                    state_d = S_PAUSA;
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PAUSA: begin
                if (cup_ok_s) begin
                    state_d = S_SERVIR;
                end else begin
                    state_d = S_PAUSA;
                end
            end
            S_DEVOLVER: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_FIN;
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                armed_d = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs align with the state.
    always_comb begin
        mol_cafe_d   = (state_d == S_MOLER);
        dos_te_d     = (state_d == S_DOSIS);
        valv_agua_d  = (state_d == S_SERVIR);
        dev_moneda_d = (state_d == S_DEVOLVER);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_FIN);
    end

    // State, counter, flag and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= CNT_ZERO;
            armed_q      <= 1'b0;
            err_q        <= 1'b0;
            mol_cafe_q   <= 1'b0;
            dos_te_q     <= 1'b0;
            valv_agua_q  <= 1'b0;
            dev_moneda_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            err_q        <= err_d;
            mol_cafe_q   <= mol_cafe_d;
            dos_te_q     <= dos_te_d;
            valv_agua_q  <= valv_agua_d;
            dev_moneda_q <= dev_moneda_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.mol_cafe   = mol_cafe_q;
    assign bus.dos_te     = dos_te_q;
    assign bus.valv_agua  = valv_agua_q;
    assign bus.dev_moneda = dev_moneda_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef ACTUADOR_CUP_SENSE_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif
endmodule

// File: doc/actuador_maquina.md
ACTUADOR_MAQUINA -- requirements
Module: actuador_maquina

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and rst.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port cmd, input, 3, command level from the coffee-machine FSM: 000 none, 001 serve coffee, 010 serve tea, 100 return coin.
REQ-005 Port taza, input, 1, cup-present sensor (1 = cup under spout).
REQ-006 Port mol_cafe, output, 1, grinder motor enable.
REQ-007 Port dos_te, output, 1, tea doser enable.
REQ-008 Port valv_agua, output, 1, hot-water valve enable.
REQ-009 Port dev_moneda, output, 1, coin-return solenoid enable.
REQ-010 Port busy, output, 1, high in every state except IDLE.
REQ-011 Port done, output, 1, one-cycle pulse when a command completes.
REQ-012 Port err, output, 1, one-cycle pulse on a refused service.
REQ-013 Parameter T_MOLER, default 8, grinder cycles.
REQ-014 Parameter T_TE, default 4, tea dosing cycles.
REQ-015 Parameter T_AGUA, default 16, water cycles, counted only while the valve is open.
REQ-016 Parameter T_DEV, default 4, solenoid cycles.

Function
REQ-017 States SHALL be IDLE, MOLER, DOSIS, SERVIR, PAUSA, DEVOLVER, FIN.
REQ-018 An armed flag SHALL be cleared on entering FIN and set when cmd==000 is sampled in IDLE; IDLE SHALL accept a command only when the flag is set.
REQ-019 Sampling armed IDLE with cmd==001 SHALL enter MOLER next cycle; 010 SHALL enter DOSIS; 100 or any other non-zero code SHALL enter DEVOLVER.
REQ-020 mol_cafe SHALL be high during exactly T_MOLER cycles in MOLER, followed by SERVIR.
REQ-021 dos_te SHALL be high during exactly T_TE cycles in DOSIS, followed by SERVIR.
REQ-022 valv_agua SHALL be high only in SERVIR; SERVIR SHALL exit to FIN after T_AGUA cumulative open cycles.
REQ-023 In SERVIR, taza==0 SHALL move to PAUSA with valv_agua low on the next cycle; the water count SHALL be held; taza==1 in PAUSA SHALL return to SERVIR.
REQ-024 dev_moneda SHALL be high for exactly T_DEV cycles in DEVOLVER, followed by FIN.
REQ-025 FIN SHALL last one cycle with done=1, then go to IDLE.
REQ-026 Actuator outputs SHALL be registered and mutually exclusive; a single down-counter wide enough for the largest parameter SHALL time every state and SHALL be reloaded on each state entry.
REQ-027 cmd changes outside IDLE SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, armed=0, and the counter to 0 on the next rising edge, from any state.
REQ-029 rst SHALL force mol_cafe, dos_te, valv_agua, dev_moneda, busy, done and err to 0.
REQ-030 rst asserted mid-SERVIR SHALL close the valve on the next edge with no done pulse.

Configuration
REQ-031 With macro ACTUADOR_CUP_SENSE_EN defined, coffee or tea accepted with taza==0 SHALL go to DEVOLVER with err=1 for that transition cycle, and REQ-023 SHALL apply.
REQ-032 Without ACTUADOR_CUP_SENSE_EN, taza SHALL be ignored, PAUSA SHALL be unreachable, and err SHALL be tied to 0.

Verification
REQ-033 Reset, cmd=000 then 001 with taza=1 -> mol_cafe high 8 cycles, valv_agua high 16 cycles, done pulses once, busy high 25 cycles.
REQ-034 cmd=010, taza=1 -> dos_te high 4 cycles, valv_agua high 16 cycles, done once.
REQ-035 cmd=100 -> dev_moneda high 4 cycles, done once; cmd held at 100 for 40 more cycles -> no second service until cmd=000.
REQ-036 With ACTUADOR_CUP_SENSE_EN: taza=0 at cycle 5 of SERVIR for 3 cycles -> valve low 3 cycles, total open cycles still 16; cmd=001 with taza=0 -> err pulse, dev_moneda 4 cycles.
REQ-037 rst pulsed at cycle 10 of SERVIR -> all outputs 0 next cycle, no done; cmd=110 -> treated as coin return.
